// File: rtl/relobi_a_cut.sv
// relobi_a_cut: two-entry spill register on the relOBI A channel.
// It sits in front of the relOBI-to-OBI decoder and breaks the req/gnt and payload paths.
// The A payload is stored and forwarded still ECC-encoded. It is never decoded on the
// forwarding path.
// The occupancy count and the head pointer are each held as three copies. The copies are
// voted every cycle and all three are rewritten from the vote, so a single upset heals itself.
// The R channel passes straight through.
// Optional feature: define RELOBI_A_CUT_ECC_CHECK_EN to check the head entry's ECC. The
// check only raises faults; it never corrects the forwarded payload.

package relobi_a_cut_pkg;

  typedef struct packed {
    logic [38:0] addr;       // 32-bit address + 7 Hsiao check bits
    logic        we;
    logic [3:0]  be;
    logic [38:0] wdata;      // 32-bit data + 7 Hsiao check bits
    logic [3:0]  aid;
    logic [7:0]  other_ecc;  // protects we/be/aid
  } relobi_a_chan_t;

  typedef struct packed {
    logic [38:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic [5:0]  other_ecc;
  } relobi_r_chan_t;

  typedef struct packed {
    logic [2:0]     req;
    relobi_a_chan_t a;
    logic [2:0]     rready;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0]     gnt;
    logic [2:0]     rvalid;
    relobi_r_chan_t r;
  } relobi_rsp_t;

endpackage

module relobi_a_cut #(
  parameter bit          UseRReady       = 1'b1,
  parameter type         relobi_a_chan_t = relobi_a_cut_pkg::relobi_a_chan_t,
  parameter type         relobi_req_t    = relobi_a_cut_pkg::relobi_req_t,
  parameter type         relobi_rsp_t    = relobi_a_cut_pkg::relobi_rsp_t,
  parameter int unsigned FaultCntWidth   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  relobi_req_t              sbr_req_i,
  output relobi_rsp_t              sbr_rsp_o,
  output relobi_req_t              mgr_req_o,
  input  relobi_rsp_t              mgr_rsp_i,
  output logic                     fault_o,
  output logic [FaultCntWidth-1:0] fault_cnt_o
);

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic [1:0] maj3_vec(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic split3(input logic [2:0] v);
    return (v != 3'b000) && (v != 3'b111);
  endfunction

  logic [2:0][1:0]          occ_q;
  logic [1:0]               occ_d;
  logic [2:0]               head_q;
  logic                     head_d;
  relobi_a_chan_t           slot_q [2];
  relobi_a_chan_t           head_a;
  logic [1:0]               occ_v, occ_eff;
  logic                     head_v, tail;
  logic                     in_valid, out_ready, gnt, push, pop;
  logic                     state_fault, ecc_fault;
  logic [FaultCntWidth-1:0] fault_cnt_q, fault_cnt_d;

  // Vote the handshakes and the replicated state, then compute a single next state
  always_comb begin
    in_valid  = maj3(sbr_req_i.req);
    out_ready = maj3(mgr_rsp_i.gnt);
    occ_v     = maj3_vec(occ_q[0], occ_q[1], occ_q[2]);
    head_v    = maj3(head_q);
    // An illegal count of 3 is treated as full, so the slice drains back to a legal state.
    occ_eff   = (occ_v == 2'd3) ? 2'd2 : occ_v;
    gnt       = (occ_eff < 2'd2);
    push      = in_valid && gnt;
    pop       = out_ready && (occ_eff != 2'd0);
    tail      = head_v ^ occ_eff[0];
    occ_d     = occ_eff + {1'b0, push} - {1'b0, pop};
    head_d    = pop ? ~head_v : head_v;
    head_a    = slot_q[head_v];
  end

  // Replicated control state: every copy is rewritten from the voted next value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q  <= '0;
      head_q <= '0;
    end else begin
      occ_q  <= {3{occ_d}};
      head_q <= {3{head_d}};
    end
  end

  // Payload slots hold data only and are not reset
  always_ff @(posedge clk_i) begin
    if (push) slot_q[tail] <= sbr_req_i.a;
  end

  // Redundancy faults: split input triples, diverged copies, or an illegal count
  always_comb begin
    state_fault = split3(sbr_req_i.req) || split3(mgr_rsp_i.gnt) ||
                  (occ_q[0] != occ_q[1]) || (occ_q[0] != occ_q[2]) ||
                  (occ_v == 2'd3) || split3(head_q);
    fault_o     = state_fault || ecc_fault;
  end

`ifdef RELOBI_A_CUT_ECC_CHECK_EN
  // The default relOBI buses carry 32-bit addr/wdata protected by Hsiao codes.
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  logic [1:0] addr_err, wdata_err;
  logic       other_fault;

  hsiao_ecc_dec #(
    .DataWidth (AddrWidth)
  ) i_addr_dec (
    .in         (head_a.addr),
    .out        (),
    .syndrome_o (),
    .err_o      (addr_err)
  );

  hsiao_ecc_dec #(
    .DataWidth (DataWidth)
  ) i_wdata_dec (
    .in         (head_a.wdata),
    .out        (),
    .syndrome_o (),
    .err_o      (wdata_err)
  );

  relobi_a_other_decoder #(
    .relobi_a_chan_t (relobi_a_chan_t)
  ) i_other_dec (
    .a_i     (head_a),
    .fault_o (other_fault)
  );

  // A bad syndrome matters only while the head slot holds a live entry.
  always_comb begin
    ecc_fault = (occ_eff != 2'd0) && ((addr_err != 2'b00) || (wdata_err != 2'b00) || other_fault);
  end
`else
  // Without the checker, faults come only from the redundancy logic.
  always_comb begin
    ecc_fault = 1'b0;
  end
`endif

  // Handshake and pass-through outputs. gnt depends only on registered state.
  always_comb begin
    sbr_rsp_o        = '0;
    sbr_rsp_o.gnt    = {3{gnt}};
    sbr_rsp_o.rvalid = mgr_rsp_i.rvalid;
    sbr_rsp_o.r      = mgr_rsp_i.r;
    mgr_req_o        = '0;
    mgr_req_o.req    = {3{occ_eff != 2'd0}};
    mgr_req_o.a      = head_a;
    mgr_req_o.rready = UseRReady ? sbr_req_i.rready : 3'b111;
  end

  // Next value of the saturating fault counter; clear wins over an increment
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (clear_i) begin
      fault_cnt_d = '0;
    end else if (fault_o && (fault_cnt_q != {FaultCntWidth{1'b1}})) begin
      fault_cnt_d = fault_cnt_q + FaultCntWidth'(1);
    end
  end

  // Fault counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_cnt_q <= '0;
    else         fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_relobi_a_cut.sv
// Testbench for relobi_a_cut: hand-checked vector table, corner-case sequences, and random
// traffic. All of it is checked against a queue-based model of a two-deep FIFO.
module tb_relobi_a_cut;
  import relobi_a_cut_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  relobi_req_t sbr_req, mgr_req;
  relobi_rsp_t sbr_rsp, mgr_rsp;
  logic        fault;
  logic [7:0]  fault_cnt;

  always #5 clk = ~clk;

  relobi_a_cut dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .sbr_req_i   (sbr_req),
    .sbr_rsp_o   (sbr_rsp),
    .mgr_req_o   (mgr_req),
    .mgr_rsp_i   (mgr_rsp),
    .fault_o     (fault),
    .fault_cnt_o (fault_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the queue holds the accepted, not yet drained transactions.
  relobi_a_chan_t mq[$];
  int             mcnt;

  // Outputs captured during the most recent step.
  logic [2:0]  act_req, act_gnt;
  logic        act_fault;
  logic [7:0]  act_cnt;
  logic [38:0] act_addr;

  typedef struct {
    logic [2:0]  req;
    logic [38:0] addr;
    logic [2:0]  gnt;
    logic [2:0]  e_req;
    logic [2:0]  e_gnt;
    logic [38:0] e_head;
    logic        e_fault;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic relobi_a_chan_t mk_a(input logic [38:0] addr);
    relobi_a_chan_t a;
    a.addr      = addr;
    a.we        = 1'($urandom);
    a.be        = 4'($urandom);
    a.wdata     = {7'($urandom), $urandom};
    a.aid       = 4'($urandom);
    a.other_ecc = 8'($urandom);
    return a;
  endfunction

  function automatic logic [2:0] rnd_triple();
    if ($urandom_range(0, 7) == 0) return 3'($urandom);
    return {3{1'($urandom)}};
  endfunction

  // One clock cycle: drive at the falling edge, check mid-cycle, then advance the model.
  task automatic step(input logic [2:0] req, input relobi_a_chan_t a, input logic [2:0] gnt,
                      input logic clr, input bit inj);
    logic [2:0]     rv, rr;
    relobi_r_chan_t r;
    logic           exp_fault, acc, drn;
    @(negedge clk);
    rv              = {3{1'($urandom)}};
    rr              = 3'($urandom);
    r.rdata         = {7'($urandom), $urandom};
    r.rid           = 4'($urandom);
    r.err           = 1'($urandom);
    r.other_ecc     = 6'($urandom);
    sbr_req.req     = req;
    sbr_req.a       = a;
    sbr_req.rready  = rr;
    mgr_rsp.gnt     = gnt;
    mgr_rsp.rvalid  = rv;
    mgr_rsp.r       = r;
    clear           = clr;
    if (inj) force dut.occ_q = 6'b01_11_01;
    #1;
    exp_fault = ($countones(req) == 1) || ($countones(req) == 2) ||
                ($countones(gnt) == 1) || ($countones(gnt) == 2) || inj;
    act_req   = mgr_req.req;
    act_gnt   = sbr_rsp.gnt;
    act_fault = fault;
    act_cnt   = fault_cnt;
    act_addr  = mgr_req.a.addr;
    check("model req", 128'(mgr_req.req), 128'((mq.size() > 0) ? 3'b111 : 3'b000));
    check("model gnt", 128'(sbr_rsp.gnt), 128'((mq.size() < 2) ? 3'b111 : 3'b000));
    check("model fault", 128'(fault), 128'(exp_fault));
    check("model fault_cnt", 128'(fault_cnt), 128'(mcnt));
    if (mq.size() > 0) check("model head payload", 128'(mgr_req.a), 128'(mq[0]));
    check("r passthrough", 128'({sbr_rsp.rvalid, sbr_rsp.r}), 128'({rv, r}));
    check("rready passthrough", 128'(mgr_req.rready), 128'(rr));
    if (inj) release dut.occ_q;
    acc = ($countones(req) >= 2) && (mq.size() < 2);
    drn = ($countones(gnt) >= 2) && (mq.size() > 0);
    if (drn) mq.delete(0);
    if (acc) mq.push_back(a);
    if (clr) mcnt = 0;
    else if (exp_fault && mcnt < 255) mcnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    // req, addr, gnt | exp req, exp gnt, exp head addr, exp fault, exp fault_cnt
    tbl[0]  = '{3'b111, 39'h10, 3'b111, 3'b000, 3'b111, 39'h00, 1'b0, 8'd0};
    tbl[1]  = '{3'b111, 39'h14, 3'b111, 3'b111, 3'b111, 39'h10, 1'b0, 8'd0};
    tbl[2]  = '{3'b111, 39'h18, 3'b111, 3'b111, 3'b111, 39'h14, 1'b0, 8'd0};
    tbl[3]  = '{3'b000, 39'h00, 3'b111, 3'b111, 3'b111, 39'h18, 1'b0, 8'd0};
    tbl[4]  = '{3'b000, 39'h00, 3'b000, 3'b000, 3'b111, 39'h00, 1'b0, 8'd0};
    tbl[5]  = '{3'b111, 39'h20, 3'b000, 3'b000, 3'b111, 39'h00, 1'b0, 8'd0};
    tbl[6]  = '{3'b111, 39'h24, 3'b000, 3'b111, 3'b111, 39'h20, 1'b0, 8'd0};
    tbl[7]  = '{3'b111, 39'h28, 3'b000, 3'b111, 3'b000, 39'h20, 1'b0, 8'd0};
    tbl[8]  = '{3'b111, 39'h28, 3'b111, 3'b111, 3'b000, 39'h20, 1'b0, 8'd0};
    tbl[9]  = '{3'b111, 39'h28, 3'b111, 3'b111, 3'b111, 39'h24, 1'b0, 8'd0};
    tbl[10] = '{3'b000, 39'h00, 3'b111, 3'b111, 3'b111, 39'h28, 1'b0, 8'd0};
    tbl[11] = '{3'b000, 39'h00, 3'b000, 3'b000, 3'b111, 39'h00, 1'b0, 8'd0};
    tbl[12] = '{3'b011, 39'h30, 3'b000, 3'b000, 3'b111, 39'h00, 1'b1, 8'd0};
    tbl[13] = '{3'b000, 39'h00, 3'b000, 3'b111, 3'b111, 39'h30, 1'b0, 8'd1};
    tbl[14] = '{3'b000, 39'h00, 3'b111, 3'b111, 3'b111, 39'h30, 1'b0, 8'd1};
    tbl[15] = '{3'b000, 39'h00, 3'b000, 3'b000, 3'b111, 39'h00, 1'b0, 8'd1};
    tbl[16] = '{3'b000, 39'h00, 3'b110, 3'b000, 3'b111, 39'h00, 1'b1, 8'd1};
    tbl[17] = '{3'b000, 39'h00, 3'b000, 3'b000, 3'b111, 39'h00, 1'b0, 8'd2};

    rst_n   = 1'b0;
    clear   = 1'b0;
    sbr_req = '0;
    mgr_rsp = '0;
    mcnt    = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset req", 128'(mgr_req.req), 128'(3'b000));
    check("reset gnt", 128'(sbr_rsp.gnt), 128'(3'b111));
    check("reset fault", 128'(fault), 128'(1'b0));
    check("reset fault_cnt", 128'(fault_cnt), 128'(8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-checked vectors: back-to-back pushes, a stalled downstream, and split triples
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, mk_a(tbl[i].addr), tbl[i].gnt, 1'b0, 1'b0);
      check($sformatf("vec%0d req", i), 128'(act_req), 128'(tbl[i].e_req));
      check($sformatf("vec%0d gnt", i), 128'(act_gnt), 128'(tbl[i].e_gnt));
      check($sformatf("vec%0d fault", i), 128'(act_fault), 128'(tbl[i].e_fault));
      check($sformatf("vec%0d fault_cnt", i), 128'(act_cnt), 128'(tbl[i].e_cnt));
      if (tbl[i].e_req == 3'b111)
        check($sformatf("vec%0d head addr", i), 128'(act_addr), 128'(tbl[i].e_head));
    end

    // Upset one occupancy copy while one entry is held; it must self-heal in one cycle
    step(3'b111, mk_a(39'h40), 3'b000, 1'b0, 1'b0);
    step(3'b000, mk_a(39'h0), 3'b000, 1'b0, 1'b1);
    check("upset fault", 128'(act_fault), 128'(1'b1));
    check("upset req", 128'(act_req), 128'(3'b111));
    check("upset head", 128'(act_addr), 128'(39'h40));
    step(3'b000, mk_a(39'h0), 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      check($sformatf("healed copy%0d", k), 128'(dut.occ_q[k]), 128'(2'd1));
    check("upset counted once", 128'(act_cnt), 128'(8'd3));
    step(3'b000, mk_a(39'h0), 3'b111, 1'b0, 1'b0);

    // Saturate the fault counter, then clear it in the same cycle as another fault
    for (int i = 0; i < 300; i++) step(3'b000, mk_a(39'h0), 3'b100, 1'b0, 1'b0);
    step(3'b000, mk_a(39'h0), 3'b100, 1'b1, 1'b0);
    check("saturated fault_cnt", 128'(act_cnt), 128'(8'hff));
    step(3'b000, mk_a(39'h0), 3'b000, 1'b0, 1'b0);
    check("clear over fault", 128'(act_cnt), 128'(8'd0));

    // Reset with two entries held drops both
    step(3'b111, mk_a(39'h50), 3'b000, 1'b0, 1'b0);
    step(3'b111, mk_a(39'h54), 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n       = 1'b0;
    sbr_req.req = 3'b000;
    mgr_rsp.gnt = 3'b000;
    #1;
    check("midreset req", 128'(mgr_req.req), 128'(3'b000));
    check("midreset gnt", 128'(sbr_rsp.gnt), 128'(3'b111));
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(rnd_triple(), mk_a({7'($urandom), $urandom}), rnd_triple(),
           ($urandom_range(0, 31) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
